// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op encoding, bus sizes,
// FSM states and the small decode helpers used by the datapath.
package cpu_defs;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LBU = 3'd1,
      LH  = 3'd2,
      LHU = 3'd3,
      LW  = 3'd4,
      SB  = 3'd5,
      SH  = 3'd6,
      SW  = 3'd7
   } mem_op_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      DONE   = 3'd3,
      CANCEL = 3'd4
   } mem_state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   function automatic logic is_store(input mem_op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   function automatic logic [1:0] op_size(input mem_op_t op);
      case (op)
         LB, LBU, SB: return SZ_BYTE;
         LH, LHU, SH: return SZ_HALF;
         default:     return SZ_WORD;
      endcase
   endfunction

   // Halfword ops need bit 0 clear, word ops need both low bits clear.
   function automatic logic misaligned(input mem_op_t op, input logic [1:0] lo);
      case (op)
         LH, LHU, SH: return lo[0];
         LW, SW:      return lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input mem_op_t op, input logic [1:0] lo);
      case (op)
         SB:      return 4'b0001 << lo;
         SH:      return lo[1] ? 4'b1100 : 4'b0011;
         SW:      return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Store data is replicated across lanes so the strobes alone pick the target bytes.
   function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] wd);
      case (op)
         SB:      return {4{wd[7:0]}};
         SH:      return {2{wd[15:0]}};
         SW:      return wd;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Combinational load-data extraction: picks the addressed byte/half out of
// the raw bus word and sign- or zero-extends it according to the op.
module load_extend
   import cpu_defs::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  lo,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (lo)
         2'd0:    byte_v = raw[7:0];
         2'd1:    byte_v = raw[15:8];
         2'd2:    byte_v = raw[23:16];
         default: byte_v = raw[31:24];
      endcase
      half_v = lo[1] ? raw[31:16] : raw[15:0];
      case (op)
         LB:      ext = {{24{byte_v[7]}}, byte_v};
         LBU:     ext = {24'h0, byte_v};
         LH:      ext = {{16{half_v[15]}}, half_v};
         LHU:     ext = {16'h0, half_v};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one SRAM-like bus transaction per
// load/store, stalls the pipeline until it completes, and flags misalignment.
module mem_access
   import cpu_defs::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  mem_op_t           mem_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              flush,
   input  logic              advance,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [3:0]        data_wstrb,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              stall,
   output logic              addr_err_load,
   output logic              addr_err_store,
   output logic [ADDR_W-1:0] badvaddr
);

   mem_state_t        state;
   mem_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] result_q;
   logic              flush_pend;
   logic [DATA_W-1:0] ext_data;
   logic              in_idle;
   logic              bad_align;
   logic              fault;
   logic              start;

   load_extend u_load_extend (
      .op  (op_q),
      .lo  (addr_q[1:0]),
      .raw (data_rdata),
      .ext (ext_data)
   );

   // Faults and the start-cycle stall come straight from the inputs; they are
   // masked while reset is held so every output reads zero during reset.
   always_comb begin
      in_idle        = rst && (state == IDLE);
      bad_align      = misaligned(mem_op, addr[1:0]);
      fault          = in_idle && in_valid && bad_align;
      start          = in_idle && in_valid && !bad_align && !flush;
      addr_err_load  = fault && !is_store(mem_op);
      addr_err_store = fault && is_store(mem_op);
      badvaddr       = fault ? addr : '0;
      stall          = start || (state == REQ) || (state == WAIT) || (state == CANCEL);
   end

   // Bus fields come only from the captured registers so they stay stable while
   // the request waits for addr_ok.
   always_comb begin
      data_req     = (state == REQ);
      data_wr      = is_store(op_q);
      data_size    = op_size(op_q);
      data_wstrb   = store_strb(op_q, addr_q[1:0]);
      data_addr    = addr_q;
      data_wdata   = store_data(op_q, wdata_q);
      result       = result_q;
      result_valid = (state == DONE);
   end

   // A request already on the bus cannot be withdrawn, so a flush seen in REQ
   // is remembered and turns the accept into a CANCEL that drains the response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_q       <= LB;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q       <= mem_op;
                  addr_q     <= addr;
                  wdata_q    <= wdata;
                  flush_pend <= 1'b0;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (data_addr_ok) begin
                  state      <= (flush || flush_pend) ? CANCEL : WAIT;
                  flush_pend <= 1'b0;
               end else if (flush) begin
                  flush_pend <= 1'b1;
               end
            end
            WAIT: begin
               if (data_data_ok) begin
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     result_q <= is_store(op_q) ? '0 : ext_data;
                     state    <= DONE;
                  end
               end else if (flush) begin
                  state <= CANCEL;
               end
            end
            DONE: begin
               if (flush || advance) state <= IDLE;
            end
            CANCEL: begin
               if (data_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
